// File: rtl/map_sst_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : map_sst_engine
// Description : Save-state sequencer placed in front of a mapper's sst port.
//               SAVE walks register addresses 0..REG_COUNT-1. For each one it
//               samples sst_di and sends the byte out on the tx stream.
//               LOAD takes bytes from the rx stream and writes each one back
//               through sst_we_reg/sst_dato. Each write is held until enough
//               synchronized M2 falling edges have been seen, because the
//               mapper registers are clocked on negedge M2.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               save_req, load_req     - start requests (sampled in IDLE)
//               busy, done, err        - status (done = 1-cycle pulse,
//                                        err = sticky M2 timeout flag)
//               m2                     - CPU M2, asynchronous to clk
//               sst_act, sst_addr,     - mapper save-state interface
//               sst_we_reg, sst_dato,
//               sst_di
//               tx_data/valid/ready    - save byte stream (source)
//               rx_data/valid/ready    - load byte stream (sink)
// Revision    : 1.0 - initial release
// ============================================================================
module map_sst_engine #(
  parameter int REG_COUNT  = 128,
  parameter int SETTLE     = 2,
  parameter int M2_FALLS   = 2,
  parameter int M2_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       save_req,
  input  logic       load_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       m2,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_last_int = REG_COUNT - 1;
  localparam logic [7:0] c_last = c_last_int[7:0];

  localparam int c_settle_w = $clog2(SETTLE + 1);
  localparam int c_falls_w  = $clog2(M2_FALLS + 1);
  localparam int c_to_w     = $clog2(M2_TIMEOUT + 1);

  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE - 1);
  localparam logic [c_falls_w-1:0]  c_falls_last  = c_falls_w'(M2_FALLS - 1);
  localparam logic [c_to_w-1:0]     c_to_last     = c_to_w'(M2_TIMEOUT - 1);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_save_set  = 3'd1;
  localparam logic [2:0] c_st_save_push = 3'd2;
  localparam logic [2:0] c_st_load_pop  = 3'd3;
  localparam logic [2:0] c_st_load_wr   = 3'd4;
  localparam logic [2:0] c_st_load_rel  = 3'd5;
  localparam logic [2:0] c_st_finish    = 3'd6;
  localparam logic [2:0] c_st_err       = 3'd7;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;

  logic                  r_m2_meta;
  logic                  r_m2_sync;
  logic                  r_m2_prev;
  logic                  w_fall;

  logic [7:0]            r_addr;
  logic [7:0]            r_dato;
  logic [7:0]            r_tx_data;
  logic                  r_err;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [c_falls_w-1:0]  r_fall_cnt;
  logic [c_to_w-1:0]     r_to_cnt;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_settle_done;
  logic                  w_falls_done;
  logic                  w_timeout;

  // --------------------------------------------------------------------------
  // M2 synchronizer and falling-edge detect
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m2_meta <= 1'b0;
      r_m2_sync <= 1'b0;
      r_m2_prev <= 1'b0;
    end else begin
      r_m2_meta <= m2;
      r_m2_sync <= r_m2_meta;
      r_m2_prev <= r_m2_sync;
    end
  end

  assign w_fall = r_m2_prev & ~r_m2_sync;

  // --------------------------------------------------------------------------
  // Condition decode
  // --------------------------------------------------------------------------
  assign w_accept      = (r_state == c_st_idle) && (save_req || load_req);
  assign w_last        = (r_addr == c_last);
  assign w_settle_done = (r_settle_cnt == c_settle_last);
  // The write is released on the fall that brings the count up to M2_FALLS.
  assign w_falls_done  = w_fall && (r_fall_cnt == c_falls_last);
  assign w_timeout     = (r_to_cnt == c_to_last);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        // save has priority when both requests arrive together
        if (save_req) begin
          w_state_nxt = c_st_save_set;
        end else if (load_req) begin
          w_state_nxt = c_st_load_pop;
        end
      end
      c_st_save_set: begin
        if (w_settle_done) begin
          w_state_nxt = c_st_save_push;
        end
      end
      c_st_save_push: begin
        if (tx_ready) begin
          w_state_nxt = w_last ? c_st_finish : c_st_save_set;
        end
      end
      c_st_load_pop: begin
        if (rx_valid) begin
          w_state_nxt = c_st_load_wr;
        end
      end
      c_st_load_wr: begin
        // A fall restarts the timeout, so it takes precedence over the timeout.
        if (w_fall) begin
          if (w_falls_done) begin
            w_state_nxt = c_st_load_rel;
          end
        end else if (w_timeout) begin
          w_state_nxt = c_st_err;
        end
      end
      c_st_load_rel: begin
        w_state_nxt = w_last ? c_st_finish : c_st_load_pop;
      end
      c_st_finish: begin
        w_state_nxt = c_st_idle;
      end
      c_st_err: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    sst_act    = 1'b0;
    sst_we_reg = 1'b0;
    tx_valid   = 1'b0;
    rx_ready   = 1'b0;
    case (r_state)
      c_st_save_set: begin
        busy    = 1'b1;
        sst_act = 1'b1;
      end
      c_st_save_push: begin
        busy     = 1'b1;
        sst_act  = 1'b1;
        tx_valid = 1'b1;
      end
      c_st_load_pop: begin
        busy     = 1'b1;
        sst_act  = 1'b1;
        rx_ready = 1'b1;
      end
      c_st_load_wr: begin
        busy       = 1'b1;
        sst_act    = 1'b1;
        sst_we_reg = 1'b1;
      end
      c_st_load_rel: begin
        busy    = 1'b1;
        sst_act = 1'b1;
      end
      c_st_finish: begin
        busy = 1'b1;
        done = 1'b1;
      end
      c_st_err: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address, data latches, counters, sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= 8'h00;
      r_dato       <= 8'h00;
      r_tx_data    <= 8'h00;
      r_err        <= 1'b0;
      r_settle_cnt <= '0;
      r_fall_cnt   <= '0;
      r_to_cnt     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_addr       <= 8'h00;
            r_err        <= 1'b0;
            r_settle_cnt <= '0;
          end
        end
        c_st_save_set: begin
          if (w_settle_done) begin
            r_tx_data <= sst_di;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        c_st_save_push: begin
          if (tx_ready) begin
            r_settle_cnt <= '0;
            // The last address is kept as is, so REG_COUNT=256 never wraps.
            if (!w_last) begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        c_st_load_pop: begin
          if (rx_valid) begin
            r_dato     <= rx_data;
            r_fall_cnt <= '0;
            r_to_cnt   <= '0;
          end
        end
        c_st_load_wr: begin
          if (w_fall) begin
            r_fall_cnt <= r_fall_cnt + 1'b1;
            r_to_cnt   <= '0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        c_st_load_rel: begin
          if (!w_last) begin
            r_addr <= r_addr + 1'b1;
          end
        end
        default: begin
          r_err <= r_err;
        end
      endcase
    end
  end

  assign sst_addr = r_addr;
  assign sst_dato = r_dato;
  assign tx_data  = r_tx_data;
  assign err      = r_err;

endmodule
`default_nettype wire
